// File: rtl/pattern_pkg.sv
// Shared types for the pattern scheduler: chart word layout, FSM states, slot record.
package pattern_pkg;

  // Chart word fields: [15:8] delay frames, [7:4] command, [3:0] pattern.
  localparam int unsigned CHART_DLY_MSB = 15;
  localparam int unsigned CHART_DLY_LSB = 8;
  localparam int unsigned CHART_CMD_MSB = 7;
  localparam int unsigned CHART_CMD_LSB = 4;
  localparam int unsigned CHART_PAT_MSB = 3;
  localparam int unsigned CHART_PAT_LSB = 0;

  localparam logic [15:0] CHART_END = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LATCH,
    WAIT,
    SPAWN,
    DRAIN,
    DONE
  } sched_state_t;

  typedef struct packed {
    logic       active;
    logic [9:0] y_pos;
    logic [3:0] cmd;
    logic [3:0] pat;
  } slot_t;

endpackage

// File: rtl/slot_arbiter.sv
// Combinational hit detection over all slots; the lowest-index covering slot wins.
module slot_arbiter
  import pattern_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = 4,
  parameter int unsigned SPRITE_H  = 32
) (
  input  slot_t [NUM_SLOTS-1:0] slots_i,
  input  logic  [9:0]           next_y_i,
  output logic                  hit_o,
  output logic  [3:0]           cmd_o,
  output logic  [3:0]           pat_o,
  output logic  [4:0]           row_o
);

  // Walk from the highest index down so the lowest covering slot is written last.
  always_comb begin
    hit_o = 1'b0;
    cmd_o = 4'd0;
    pat_o = 4'd0;
    row_o = 5'd0;
    for (int i = int'(NUM_SLOTS) - 1; i >= 0; i--) begin
      if (slots_i[i].active && (next_y_i >= slots_i[i].y_pos) &&
          ({1'b0, next_y_i} < ({1'b0, slots_i[i].y_pos} + 11'(SPRITE_H)))) begin
        hit_o = 1'b1;
        cmd_o = slots_i[i].cmd;
        pat_o = slots_i[i].pat;
        row_o = 5'(next_y_i - slots_i[i].y_pos);
      end
    end
  end

endmodule

// File: rtl/pattern_scheduler.sv
// Chart-driven sequencer of falling note patterns with per-pixel slot arbitration.
// Optional feature: define PATTERN_SCHED_MISS_CNT_EN to count dropped spawns on miss_count.
module pattern_scheduler
  import pattern_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = 4,
  parameter int unsigned CHART_AW  = 8,
  parameter int unsigned FRAME_H   = 480,
  parameter int unsigned SPRITE_H  = 32,
  parameter int unsigned SPEED     = 2
) (
  input  logic                CLOCK_25,
  input  logic                reset,
  input  logic [9:0]          next_x,
  input  logic [9:0]          next_y,
  input  logic                start,
  output logic [CHART_AW-1:0] chart_addr,
  input  logic [15:0]         chart_data,
  output logic                pix_hit,
  output logic [3:0]          pix_command,
  output logic [3:0]          pix_pattern,
  output logic [4:0]          pix_row,
  output logic                busy,
  output logic                done,
  output logic [7:0]          miss_count
);

  sched_state_t          state_q, state_d;
  logic [CHART_AW-1:0]   addr_q, addr_d;
  logic [7:0]            delay_q, delay_d;
  logic [3:0]            cmd_q, cmd_d;
  logic [3:0]            pat_q, pat_d;
  logic                  start_q;
  slot_t [NUM_SLOTS-1:0] slots_q, slots_d;
  logic                  pix_hit_q;
  logic [3:0]            pix_cmd_q, pix_pat_q;
  logic [4:0]            pix_row_q;

  logic       frame_tick, start_rise, spawn_req, clear_miss, drop, placed, any_active;
  logic [10:0] adv;
  logic       arb_hit;
  logic [3:0] arb_cmd, arb_pat;
  logic [4:0] arb_row;

  assign frame_tick = (next_x == 10'd0) && (next_y == 10'(FRAME_H));
  assign start_rise = start && !start_q;

  // Chart sequencing: fetch a word, wait out its delay in frames, then spawn it.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    delay_d    = delay_q;
    cmd_d      = cmd_q;
    pat_d      = pat_q;
    spawn_req  = 1'b0;
    clear_miss = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_rise) begin
          state_d    = FETCH;
          addr_d     = '0;
          clear_miss = 1'b1;
        end
      end
      FETCH: state_d = LATCH;
      LATCH: begin
        if (chart_data == CHART_END) begin
          state_d = DRAIN;
        end else begin
          delay_d = chart_data[CHART_DLY_MSB:CHART_DLY_LSB];
          cmd_d   = chart_data[CHART_CMD_MSB:CHART_CMD_LSB];
          pat_d   = chart_data[CHART_PAT_MSB:CHART_PAT_LSB];
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (delay_q == 8'd0) begin
          state_d = SPAWN;
        end else if (frame_tick) begin
          delay_d = delay_q - 8'd1;
          if (delay_q == 8'd1) state_d = SPAWN;
        end
      end
      SPAWN: begin
        spawn_req = 1'b1;
        // The last ROM address doubles as an implicit end of chart.
        if (addr_q == '1) begin
          state_d = DRAIN;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = FETCH;
        end
      end
      DRAIN: if (!any_active) state_d = DONE;
      DONE:  if (!start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Slot motion on frame_tick, then placement of a new entry into the lowest free slot.
  always_comb begin
    slots_d    = slots_q;
    adv        = 11'd0;
    placed     = 1'b0;
    any_active = 1'b0;
    for (int i = 0; i < int'(NUM_SLOTS); i++) begin
      any_active = any_active | slots_q[i].active;
      if (frame_tick && (state_q != IDLE) && slots_q[i].active) begin
        adv              = {1'b0, slots_q[i].y_pos} + 11'(SPEED);
        slots_d[i].y_pos = adv[9:0];
        if (adv >= 11'(FRAME_H)) slots_d[i].active = 1'b0;
      end
    end
    // Freedom is judged on the pre-advance state, so a new slot never moves this frame.
    for (int i = 0; i < int'(NUM_SLOTS); i++) begin
      if (spawn_req && !placed && !slots_q[i].active) begin
        slots_d[i] = '{active: 1'b1, y_pos: 10'd0, cmd: cmd_q, pat: pat_q};
        placed     = 1'b1;
      end
    end
    drop = spawn_req && !placed;
  end

  slot_arbiter #(
    .NUM_SLOTS(NUM_SLOTS),
    .SPRITE_H (SPRITE_H)
  ) u_arb (
    .slots_i (slots_q),
    .next_y_i(next_y),
    .hit_o   (arb_hit),
    .cmd_o   (arb_cmd),
    .pat_o   (arb_pat),
    .row_o   (arb_row)
  );

  // All sequential state, including the registered pixel outputs.
  always_ff @(posedge CLOCK_25) begin
    if (!reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      delay_q   <= 8'd0;
      cmd_q     <= 4'd0;
      pat_q     <= 4'd0;
      start_q   <= 1'b0;
      slots_q   <= '0;
      pix_hit_q <= 1'b0;
      pix_cmd_q <= 4'd0;
      pix_pat_q <= 4'd0;
      pix_row_q <= 5'd0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      delay_q   <= delay_d;
      cmd_q     <= cmd_d;
      pat_q     <= pat_d;
      start_q   <= start;
      slots_q   <= slots_d;
      pix_hit_q <= arb_hit;
      pix_cmd_q <= arb_cmd;
      pix_pat_q <= arb_pat;
      pix_row_q <= arb_row;
    end
  end

  assign chart_addr  = addr_q;
  assign pix_hit     = pix_hit_q;
  assign pix_command = pix_cmd_q;
  assign pix_pattern = pix_pat_q;
  assign pix_row     = pix_row_q;
  assign busy        = (state_q != IDLE) && (state_q != DONE);
  assign done        = (state_q == DONE);

`ifdef PATTERN_SCHED_MISS_CNT_EN
  logic [7:0] miss_q, miss_d;

  // Saturating drop counter, restarted each time a chart is launched.
  always_comb begin
    miss_d = miss_q;
    if (clear_miss) begin
      miss_d = 8'd0;
    end else if (drop && (miss_q != 8'hFF)) begin
      miss_d = miss_q + 8'd1;
    end
  end

  // Counter register.
  always_ff @(posedge CLOCK_25) begin
    if (!reset) miss_q <= 8'd0;
    else        miss_q <= miss_d;
  end

  assign miss_count = miss_q;
`else
  logic unused_miss;
  assign unused_miss = drop ^ clear_miss;
  assign miss_count  = 8'd0;
`endif

endmodule
